ascii_num_parser: RTL

ASCII_NUM_PARSER -- requirements
Module: ascii_num_parser

---
 rtl/ascii_num_parser_pkg.sv | 30 +++
 rtl/ascii_digit_decode.sv | 37 +++
 rtl/ascii_num_parser.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ascii_num_parser_pkg.sv
// Shared constants, FSM state type and radix helper for the ASCII number parser.
package ascii_num_parser_pkg;

  localparam logic [1:0] RADIX_DEC     = 2'b00;
  localparam logic [1:0] RADIX_HEX     = 2'b01;
  localparam logic [1:0] RADIX_BIN     = 2'b10;
  localparam logic [1:0] RADIX_DEC_ALT = 2'b11;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [4:0] radix_base(input logic [1:0] r);
    case (r)
      RADIX_HEX:                radix_base = 5'd16;
      RADIX_BIN:                radix_base = 5'd2;
      RADIX_DEC, RADIX_DEC_ALT: radix_base = 5'd10;
      default:                  radix_base = 5'd10;
    endcase
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational character classifier: digit value, legality for the radix, terminator flag.
module ascii_digit_decode
  import ascii_num_parser_pkg::*;
(
  input  logic [7:0] i_char,
  input  logic [1:0] i_radix,
  output logic [3:0] o_digit_c,
  output logic       o_legal_c,
  output logic       o_term_c
);

  logic w_is_num;
  logic w_is_upper;
  logic w_is_lower;
  logic w_is_bin;

  assign w_is_num   = (i_char >= 8'h30) && (i_char <= 8'h39);
  assign w_is_upper = (i_char >= 8'h41) && (i_char <= 8'h46);
  assign w_is_lower = (i_char >= 8'h61) && (i_char <= 8'h66);
  assign w_is_bin   = (i_char == 8'h30) || (i_char == 8'h31);

  always_comb begin
    o_digit_c = 4'd0;
    o_legal_c = 1'b0;
    if (w_is_num)        o_digit_c = 4'(i_char - 8'h30);
    else if (w_is_upper) o_digit_c = 4'(i_char - 8'h37);
    else if (w_is_lower) o_digit_c = 4'(i_char - 8'h57);
    case (i_radix)
      RADIX_HEX: o_legal_c = w_is_num | w_is_upper | w_is_lower;
      RADIX_BIN: o_legal_c = w_is_bin;
      default:   o_legal_c = w_is_num;
    endcase
  end

  assign o_term_c = (i_char == CH_SPACE) || (i_char == CH_LF) || (i_char == CH_CR);

endmodule

// File: rtl/ascii_num_parser.sv
// Streaming ASCII integer parser (decimal/hex/binary) with saturation and error reporting.
// Define ASCII_NUM_PARSER_SIGN_EN to accept a leading '-' and produce two's-complement results.
module ascii_num_parser
  import ascii_num_parser_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic [1:0]        radix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic              out_error,
  output logic              out_overflow
);

  localparam int unsigned CALC_W = DATA_W + 5;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_acc;
  logic                r_err;
  logic                r_ovf;
  logic [1:0]          r_radix;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_value;
  logic                r_out_error;
  logic                r_out_overflow;

  logic [1:0]          w_radix_eff;
  logic [3:0]          w_digit;
  logic                w_legal;
  logic                w_term;
  logic                w_xfer;
  logic                w_minus_ok;
  logic                w_done_entry;
  logic [CALC_W-1:0]   w_acc_base;
  logic [CALC_W-1:0]   w_prod;
  logic [CALC_W-1:0]   w_limit;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic                w_ovf_nxt;
  logic [DATA_W-1:0]   w_result;
  logic                w_in_ready_nxt;
  logic                w_out_valid_nxt;

  // First digit of a token is classified with the live radix, the rest with the latched one.
  assign w_radix_eff = (r_state == IDLE) ? radix : r_radix;

  ascii_digit_decode u_decode (
    .i_char    (in_char),
    .i_radix   (w_radix_eff),
    .o_digit_c (w_digit),
    .o_legal_c (w_legal),
    .o_term_c  (w_term)
  );

  assign w_xfer     = in_valid & r_in_ready;
  assign w_acc_base = (r_state == IDLE) ? '0 : CALC_W'(r_acc);
  assign w_prod     = w_acc_base * CALC_W'(radix_base(w_radix_eff)) + CALC_W'(w_digit);

`ifdef ASCII_NUM_PARSER_SIGN_EN
  logic r_neg;

  assign w_minus_ok = (r_state == IDLE) && (in_char == CH_MINUS) && !r_neg;
  assign w_limit    = r_neg ? (CALC_W'(1) << (DATA_W - 1))
                            : (CALC_W'(1) << (DATA_W - 1)) - CALC_W'(1);
  assign w_result   = r_neg ? (DATA_W'(0) - r_acc) : r_acc;

  always_ff @(posedge clk) begin
    if (rst)                                  r_neg <= 1'b0;
    else if ((r_state == DONE) && out_ready)  r_neg <= 1'b0;
    else if (w_xfer && w_minus_ok)            r_neg <= 1'b1;
  end
`else
  assign w_minus_ok = 1'b0;
  assign w_limit    = CALC_W'({DATA_W{1'b1}});
  assign w_result   = r_acc;
`endif

  // Saturating accumulate; once overflowed the value is pinned at the limit.
  always_comb begin
    w_acc_nxt = DATA_W'(w_prod);
    w_ovf_nxt = r_ovf;
    if (r_ovf || (w_prod > w_limit)) begin
      w_acc_nxt = DATA_W'(w_limit);
      w_ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_xfer && !w_term && !w_minus_ok) w_state_nxt = w_legal ? ACCUM : SKIP;
      ACCUM: if (w_xfer) begin
               if (w_term)        w_state_nxt = DONE;
               else if (!w_legal) w_state_nxt = SKIP;
             end
      SKIP:  if (w_xfer && w_term) w_state_nxt = DONE;
      DONE:  if (out_ready)        w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready_nxt  = 1'b1;
    w_out_valid_nxt = 1'b0;
    if (w_state_nxt == DONE) begin
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b1;
    end
  end

  assign w_done_entry = (r_state != DONE) && (w_state_nxt == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc          <= '0;
      r_err          <= 1'b0;
      r_ovf          <= 1'b0;
      r_radix        <= RADIX_DEC;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_value    <= '0;
      r_out_error    <= 1'b0;
      r_out_overflow <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      case (r_state)
        IDLE: if (w_xfer && !w_term) begin
                if (w_legal) begin
                  r_radix <= radix;
                  r_acc   <= w_acc_nxt;
                  r_ovf   <= w_ovf_nxt;
                end else if (!w_minus_ok) begin
                  r_err <= 1'b1;
                end
              end
        ACCUM: if (w_xfer && !w_term) begin
                 if (w_legal) begin
                   r_acc <= w_acc_nxt;
                   r_ovf <= w_ovf_nxt;
                 end else begin
                   r_err <= 1'b1;
                 end
               end
        DONE: if (out_ready) begin
                r_acc          <= '0;
                r_err          <= 1'b0;
                r_ovf          <= 1'b0;
                r_radix        <= RADIX_DEC;
                r_out_value    <= '0;
                r_out_error    <= 1'b0;
                r_out_overflow <= 1'b0;
              end
        default: ;
      endcase
      // An errored token reports zero value and no overflow.
      if (w_done_entry) begin
        r_out_value    <= r_err ? '0 : w_result;
        r_out_error    <= r_err;
        r_out_overflow <= r_ovf & ~r_err;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_value    = r_out_value;
  assign out_error    = r_out_error;
  assign out_overflow = r_out_overflow;

endmodule
